// File: rtl/vga_ball_pkg.sv
// Shared constants for the sprite register bank: sprite indices, the
// register map, the power-on sprite layout and the score clamp helper.
package vga_ball_pkg;

  localparam int NUM_SPRITES = 7;
  localparam int POS_W       = 10;
  localparam int ADDR_W      = 9;
  localparam int DATA_W      = 32;
  localparam int PERIOD_W    = 6;
  localparam int SCORE_W     = 16;

  typedef enum logic [2:0] {
    SPR_DINO     = 3'd0,
    SPR_JUMP     = 3'd1,
    SPR_DUCK     = 3'd2,
    SPR_S_CAC    = 3'd3,
    SPR_GODZILLA = 3'd4,
    SPR_POWERUP  = 3'd5,
    SPR_PTR      = 3'd6
  } sprite_e;

  // Word addresses; 0..13 interleave x (even) and y (odd) per sprite.
  localparam logic [ADDR_W-1:0] ADDR_POS_LAST = 9'd13;
  localparam logic [ADDR_W-1:0] ADDR_SCORE    = 9'd14;
  localparam logic [ADDR_W-1:0] ADDR_ENABLE   = 9'd15;
  localparam logic [ADDR_W-1:0] ADDR_CONTROL  = 9'd16;
  localparam logic [ADDR_W-1:0] ADDR_PERIOD   = 9'd17;
  localparam logic [ADDR_W-1:0] ADDR_STATUS   = 9'd18;

  localparam logic [POS_W-1:0] DEFAULT_X [NUM_SPRITES] =
    '{10'd100, 10'd200, 10'd300, 10'd500, 10'd100, 10'd130, 10'd600};
  localparam logic [POS_W-1:0] DEFAULT_Y [NUM_SPRITES] =
    '{10'd100, 10'd150, 10'd400, 10'd100, 10'd300, 10'd260, 10'd140};

  localparam logic [NUM_SPRITES-1:0] DEFAULT_ENABLE = '1;
  localparam logic [PERIOD_W-1:0]    DEFAULT_PERIOD = 6'd8;

  // Saturate every nibble to a legal BCD digit.
  function automatic logic [SCORE_W-1:0] clamp_bcd(input logic [SCORE_W-1:0] value);
    logic [SCORE_W-1:0] result;
    result = '0;
    for (int i = 0; i < SCORE_W / 4; i++) begin
      result[4*i +: 4] = (value[4*i +: 4] > 4'd9) ? 4'd9 : value[4*i +: 4];
    end
    return result;
  endfunction

endpackage

// File: rtl/anim_sequencer.sv
// Frame-rate animation divider: every anim_period frames the walk cycle
// advances 0->1->2->0 and the pointer blink phase toggles.
module anim_sequencer
  import vga_ball_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                frame_start,
  input  logic [PERIOD_W-1:0] anim_period,
  output logic [1:0]          walk_phase,
  output logic                ptr_phase
);

  logic [PERIOD_W-1:0] anim_cnt;
  logic [PERIOD_W-1:0] last_count;

  // A period of 0 behaves as 1; comparing with >= keeps the counter from
  // running the long way round when the period is shortened mid-count.
  assign last_count = (anim_period == '0) ? '0 : anim_period - PERIOD_W'(1);

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      anim_cnt   <= '0;
      walk_phase <= 2'd0;
      ptr_phase  <= 1'b0;
    end else if (frame_start) begin
      if (anim_cnt >= last_count) begin
        anim_cnt   <= '0;
        walk_phase <= (walk_phase == 2'd2) ? 2'd0 : walk_phase + 2'd1;
        ptr_phase  <= ~ptr_phase;
      end else begin
        anim_cnt <= anim_cnt + PERIOD_W'(1);
      end
    end
  end

endmodule

// File: rtl/sprite_reg_bank.sv
// Avalon-MM sprite register bank: CPU writes land in a shadow copy that is
// transferred to the display-facing registers at the start of vertical blank.
module sprite_reg_bank
  import vga_ball_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   chipselect,
  input  logic                   write,
  input  logic                   read,
  input  logic [ADDR_W-1:0]      address,
  input  logic [DATA_W-1:0]      writedata,
  output logic [DATA_W-1:0]      readdata,
  input  logic                   frame_start,
  output logic [POS_W-1:0]       spr_x [NUM_SPRITES],
  output logic [POS_W-1:0]       spr_y [NUM_SPRITES],
  output logic [NUM_SPRITES-1:0] spr_en,
  output logic [SCORE_W-1:0]     score_bcd,
  output logic [1:0]             walk_phase,
  output logic                   ptr_phase,
  output logic [15:0]            frame_count,
  output logic                   commit_ack
);

  logic [POS_W-1:0]       shadow_x [NUM_SPRITES];
  logic [POS_W-1:0]       shadow_y [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] shadow_en;
  logic [SCORE_W-1:0]     shadow_score;
  logic [PERIOD_W-1:0]    anim_period;
  logic                   commit_pending;
  logic [DATA_W-1:0]      read_mux;

  logic    wr_en;
  logic    rd_en;
  logic    addr_is_pos;
  logic    commit_req;
  logic    commit_now;
  sprite_e sprite_sel;
  logic    unused_writedata;

  assign wr_en       = chipselect && write;
  assign rd_en       = chipselect && read;
  assign addr_is_pos = (address <= ADDR_POS_LAST);
  assign sprite_sel  = sprite_e'(address[3:1]);
  assign commit_req  = wr_en && (address == ADDR_CONTROL) && writedata[0];
  assign commit_now  = frame_start && commit_pending;

  assign unused_writedata = ^writedata[DATA_W-1:SCORE_W];

  // NOTE: the position tables are small register arrays with architected
  // power-on values, so they are reset like any other register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_SPRITES; k++) begin
        shadow_x[k] <= DEFAULT_X[k];
        shadow_y[k] <= DEFAULT_Y[k];
      end
      shadow_en    <= DEFAULT_ENABLE;
      shadow_score <= '0;
    end else if (wr_en) begin
      if (addr_is_pos) begin
        if (address[0]) shadow_y[sprite_sel] <= writedata[POS_W-1:0];
        else            shadow_x[sprite_sel] <= writedata[POS_W-1:0];
      end else if (address == ADDR_SCORE) begin
        shadow_score <= clamp_bcd(writedata[SCORE_W-1:0]);
      end else if (address == ADDR_ENABLE) begin
        shadow_en <= writedata[NUM_SPRITES-1:0];
      end
    end
  end

  // A coincident shadow write is not yet visible here, so the copy takes
  // the pre-write shadow contents.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_SPRITES; k++) begin
        spr_x[k] <= DEFAULT_X[k];
        spr_y[k] <= DEFAULT_Y[k];
      end
      spr_en    <= DEFAULT_ENABLE;
      score_bcd <= '0;
    end else if (commit_now) begin
      for (int k = 0; k < NUM_SPRITES; k++) begin
        spr_x[k] <= shadow_x[k];
        spr_y[k] <= shadow_y[k];
      end
      spr_en    <= shadow_en;
      score_bcd <= shadow_score;
    end
  end

  // A commit request landing on a frame_start only arms the next one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      commit_pending <= 1'b0;
      commit_ack     <= 1'b0;
      anim_period    <= DEFAULT_PERIOD;
      frame_count    <= '0;
    end else begin
      commit_ack <= commit_now;
      if (commit_now)      commit_pending <= 1'b0;
      else if (commit_req) commit_pending <= 1'b1;
      if (wr_en && address == ADDR_PERIOD) anim_period <= writedata[PERIOD_W-1:0];
      if (frame_start) frame_count <= frame_count + 16'd1;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    read_mux = '0;
    if (addr_is_pos) begin
      read_mux[POS_W-1:0] = address[0] ? shadow_y[sprite_sel] : shadow_x[sprite_sel];
    end else begin
      case (address)
        ADDR_SCORE:   read_mux[SCORE_W-1:0]     = shadow_score;
        ADDR_ENABLE:  read_mux[NUM_SPRITES-1:0] = shadow_en;
        ADDR_CONTROL: read_mux[0]               = commit_pending;
        ADDR_PERIOD:  read_mux[PERIOD_W-1:0]    = anim_period;
        ADDR_STATUS:  read_mux = {frame_count, 15'b0, commit_pending};
        default:      read_mux = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   readdata <= '0;
    else if (rd_en) readdata <= read_mux;
  end

  anim_sequencer u_anim_sequencer (
    .clk         (clk),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .anim_period (anim_period),
    .walk_phase  (walk_phase),
    .ptr_phase   (ptr_phase)
  );

endmodule

// File: doc/sprite_reg_bank.md
SPRITE_REG_BANK -- requirements
Module: sprite_reg_bank

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, 50 MHz.
REQ-002 SHALL have ports: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: chipselect  in  1;  write  in  1;  read  in  1;  address  in  9;  writedata  in  32  (Avalon-MM slave, zero wait states).
REQ-004 SHALL have ports: readdata  out  32  (registered read data).
REQ-005 SHALL have ports: frame_start  in  1  (one-cycle pulse from the VGA counters at hcount==0, vcount==480, i.e. start of vertical blank).
REQ-006 SHALL have ports: spr_x[7], spr_y[7]  out  10 each  (active positions; index 0..6 = dino, jump, duck, s_cac, godzilla, powerup, ptr).
REQ-007 SHALL have ports: spr_en  out  7  (active enable mask);  score_bcd  out  16  (4 BCD digits);  walk_phase  out  2  (0,1,2);  ptr_phase  out  1;  frame_count  out  16;  commit_ack  out  1  (one-cycle pulse).

Function
REQ-008 Register map (word addresses) SHALL be: 0..13 = sprite k x (even) / y (odd), k = addr/2, writedata[9:0]; 14 = score; 15 = enable mask [6:0]; 16 = control (bit0 = commit request); 17 = anim_period [5:0]; 18 = status (read-only).
REQ-009 Writes to addresses 0..15 SHALL update the shadow copy only; active outputs SHALL NOT change until a commit.
REQ-010 A score write SHALL clamp each nibble >9 to 9 before storing in the shadow copy.
REQ-011 A write to address 16 with bit0=1 SHALL set commit_pending; repeated commit writes while pending SHALL have no further effect.
REQ-012 On frame_start with commit_pending=1, all shadow registers SHALL be copied to the active registers, commit_pending SHALL clear, and commit_ack SHALL pulse for exactly one cycle in the following cycle.
REQ-013 If a commit write and frame_start coincide, pending SHALL be set and the copy SHALL occur at the next frame_start, not the current one.
REQ-014 If a shadow write and a committing frame_start coincide, the active registers SHALL receive the pre-write shadow value, and the shadow SHALL hold the new value.
REQ-015 Address 17 SHALL write anim_period directly (not shadowed); value 0 SHALL behave as 1.
REQ-016 frame_count SHALL increment by 1 on every frame_start and wrap 0xFFFF -> 0x0000.
REQ-017 anim_cnt SHALL increment on every frame_start; when it equals max(anim_period,1)-1 it SHALL wrap to 0, walk_phase SHALL advance 0->1->2->0, and ptr_phase SHALL toggle.
REQ-018 A read with chipselect&&read SHALL drive readdata in the next cycle: 0..17 return the shadow/period value zero-extended; 18 returns {frame_count[15:0], 15'b0, commit_pending}; unmapped addresses return 0.
REQ-019 Writes and reads to addresses 19..511 SHALL be ignored.

Reset
REQ-020 On reset_n=0, outputs and registers SHALL reset as follows.
- Shadow and active positions: dino(100,100), jump(200,150), duck(300,400), s_cac(500,100), godzilla(100,300), powerup(130,260), ptr(600,140).
- spr_en = 7'h7F; score_bcd = 0; anim_period = 8; walk_phase = 0; ptr_phase = 0; frame_count = 0; anim_cnt = 0.
- commit_pending = 0; commit_ack = 0; readdata = 0.
REQ-021 Reset asserted mid-frame or with a commit pending SHALL discard the pending commit.

Structure
REQ-022 Package vga_ball_pkg SHALL hold:
- NUM_SPRITES = 7
- sprite index enum
- address-map constants
- default position table
- POS_W = 10
REQ-023 Animation counting (anim_cnt, walk_phase, ptr_phase) SHALL be a sub-module named anim_sequencer, clocked by clk/reset_n with frame_start and anim_period inputs.

Verification
REQ-024 Write addr0=250, then read addr0 -> readdata=250 one cycle later; spr_x[0] stays 100 until commit and frame_start.
REQ-025 Write addr16=1, then pulse frame_start -> spr_x/spr_y equal the shadow values, commit_ack is high for one cycle, and status bit0 = 0.
REQ-026 Write addr16=1 in the same cycle as frame_start -> no copy occurs and status bit0 = 1; the next frame_start performs the copy.
REQ-027 Write score 0x1A9F, commit, then frame_start -> score_bcd = 0x1999.
REQ-028 With anim_period=0, three frame_starts -> walk_phase sequence 1,2,0 and ptr_phase 1,0,1; with anim_period=3, 6 frame_starts -> walk_phase ends at 2.
REQ-029 Set commit pending, then assert reset_n low mid-frame -> all defaults are restored, and the next frame_start produces no commit_ack.
